branch_hazard_sequencer: RTL and testbench

Sequential hazard controller for the 5-stage MIPS pipeline. Detects load-use and branch-operand hazards for the instruction in ID, then runs a multi-cycle stall sequence with a down-counter: holds PC and IF/ID, injects ID/EX bubbles. Also issues the IF/ID flush for taken branches and jumps. Sits beside the ID-stage comparator; drives PC, IF/ID and ID/EX register enables.

---
 rtl/mips_ctrl_pkg.sv | 13 +
 rtl/branch_hazard_sequencer_hazard_classifier.sv | 32 +++
 rtl/branch_hazard_sequencer.sv | 94 +++++++++
 tb/tb_branch_hazard_sequencer.sv | 132 +++++++++++++
 4 files changed

// File: rtl/mips_ctrl_pkg.sv
// mips_ctrl_pkg: shared opcodes, sequencer state encoding and opcode helpers
package mips_ctrl_pkg;
   localparam logic [5:0] OP_RTYPE = 6'd0;
   localparam logic [5:0] OP_J     = 6'd2;
   localparam logic [5:0] OP_BEQ   = 6'd4;
   localparam logic [5:0] OP_BNE   = 6'd5;
   localparam logic [5:0] OP_LW    = 6'd35;
   localparam logic [5:0] OP_SW    = 6'd43;
   typedef enum logic {IDLE = 1'b0, STALL = 1'b1} seqState_t;
   function automatic logic isBranchOp(input logic [5:0] op);
      return op == OP_BEQ || op == OP_BNE;
   endfunction
endpackage

// File: rtl/branch_hazard_sequencer_hazard_classifier.sv
// hazard_classifier: combinational load-use / branch-operand hazard detection and required stall count
module hazard_classifier
   import mips_ctrl_pkg::*;
#(
   parameter int LW_BEQ_STALLS = 2,
   parameter int CNT_W = 2
) (
   input  logic [5:0]     idOpcode,
   input  logic [4:0]     idRs,
   input  logic [4:0]     idRt,
   input  logic           exMemread,
   input  logic           exRegwrite,
   input  logic [4:0]     exDest,
   input  logic           memMemread,
   input  logic [4:0]     memDest,
   output logic           hazard,
   output logic [CNT_W:0] needStalls
);
   logic usesRs, usesRt, isBranch, exMatch, memMatch;
   // source usage, register matches ($0 never matches) and prioritised stall count
   always_comb begin
      usesRs = idOpcode != OP_J;
      usesRt = idOpcode inside {OP_RTYPE, OP_BEQ, OP_BNE, OP_SW};
      isBranch = isBranchOp(idOpcode);
      exMatch = exDest != 5'd0 && ((usesRs && exDest == idRs) || (usesRt && exDest == idRt));
      memMatch = memDest != 5'd0 && ((usesRs && memDest == idRs) || (usesRt && memDest == idRt));
      needStalls = (exMemread && exMatch && isBranch) ? (CNT_W+1)'(LW_BEQ_STALLS)
                 : ((exMemread && exMatch) || (exRegwrite && exMatch && isBranch) ||
                    (memMemread && memMatch && isBranch)) ? (CNT_W+1)'(1) : '0;
      hazard = needStalls != '0;
   end
endmodule

// File: rtl/branch_hazard_sequencer.sv
// branch_hazard_sequencer: ID-stage stall sequencer and IF/ID flush control; HAZ_SEQ_PERF_CNT_EN adds stall/flush counters
module branch_hazard_sequencer
   import mips_ctrl_pkg::*;
#(
   parameter int LW_BEQ_STALLS = 2,
   parameter int CNT_W = 2
) (
   input  logic        clk,
   input  logic        reset,
   input  logic [5:0]  id_opcode,
   input  logic [4:0]  id_rs,
   input  logic [4:0]  id_rt,
   input  logic        ex_memread,
   input  logic        ex_regwrite,
   input  logic [4:0]  ex_dest,
   input  logic        mem_memread,
   input  logic [4:0]  mem_dest,
   input  logic        id_branch_taken,
   output logic        pc_write,
   output logic        if_id_write,
   output logic        if_id_flush,
   output logic        id_ex_bubble,
   output logic        stall_active
`ifdef HAZ_SEQ_PERF_CNT_EN
   ,
   output logic [31:0] stall_cycles,
   output logic [31:0] flush_count
`endif
);
   seqState_t state, nextState;
   logic [CNT_W-1:0] cnt, nextCnt;
   logic hazard, stall;
   logic [CNT_W:0] needStalls;

   hazard_classifier #(.LW_BEQ_STALLS(LW_BEQ_STALLS), .CNT_W(CNT_W)) classifier (
      .idOpcode(id_opcode),
      .idRs(id_rs),
      .idRt(id_rt),
      .exMemread(ex_memread),
      .exRegwrite(ex_regwrite),
      .exDest(ex_dest),
      .memMemread(mem_memread),
      .memDest(mem_dest),
      .hazard(hazard),
      .needStalls(needStalls)
   );

   // state and remaining-stall counter
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state <= IDLE;
         cnt <= '0;
      end else begin
         state <= nextState;
         cnt <= nextCnt;
      end
   end

   // single-cycle hazards stay in IDLE and re-evaluate; longer ones count down in STALL
   always_comb begin
      nextState = state;
      nextCnt = cnt;
      if (state == IDLE) begin
         if (hazard && needStalls > (CNT_W+1)'(1)) begin
            nextState = STALL;
            nextCnt = CNT_W'(needStalls - (CNT_W+1)'(2));
         end
      end else if (cnt == '0) nextState = IDLE;
      else nextCnt = cnt - CNT_W'(1);
   end

   // Mealy outputs; a stall (or reset) always wins over a branch/jump flush
   always_comb begin
      stall = reset || state == STALL || hazard;
      pc_write = !stall;
      if_id_write = !stall;
      id_ex_bubble = stall;
      if_id_flush = !stall && ((isBranchOp(id_opcode) && id_branch_taken) || id_opcode == OP_J);
      stall_active = !reset && state == STALL;
   end

`ifdef HAZ_SEQ_PERF_CNT_EN
   // saturating stall-cycle and flush event counters
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         stall_cycles <= '0;
         flush_count <= '0;
      end else begin
         if (!pc_write && stall_cycles != '1) stall_cycles <= stall_cycles + 32'd1;
         if (if_id_flush && flush_count != '1) flush_count <= flush_count + 32'd1;
      end
   end
`endif
endmodule

// File: tb/tb_branch_hazard_sequencer.sv
// tb_branch_hazard_sequencer: directed and random stimulus against a remaining-stall-cycles reference model
module tb_branch_hazard_sequencer;
   localparam int LW_BEQ_STALLS = 2;
   logic clk = 1'b0, reset = 1'b1;
   logic [5:0] id_opcode = '0;
   logic [4:0] id_rs = '0, id_rt = '0, ex_dest = '0, mem_dest = '0;
   logic ex_memread = 1'b0, ex_regwrite = 1'b0, mem_memread = 1'b0, id_branch_taken = 1'b0;
   logic pc_write, if_id_write, if_id_flush, id_ex_bubble, stall_active;
`ifdef HAZ_SEQ_PERF_CNT_EN
   logic [31:0] stall_cycles, flush_count;
   int modelStalls = 0, modelFlushes = 0;
`endif
   int checks = 0, passed = 0;
   int pending = 0;

   always #5 clk = ~clk;

   branch_hazard_sequencer #(.LW_BEQ_STALLS(LW_BEQ_STALLS), .CNT_W(2)) dut (
      .clk(clk),
      .reset(reset),
      .id_opcode(id_opcode),
      .id_rs(id_rs),
      .id_rt(id_rt),
      .ex_memread(ex_memread),
      .ex_regwrite(ex_regwrite),
      .ex_dest(ex_dest),
      .mem_memread(mem_memread),
      .mem_dest(mem_dest),
      .id_branch_taken(id_branch_taken),
      .pc_write(pc_write),
      .if_id_write(if_id_write),
      .if_id_flush(if_id_flush),
      .id_ex_bubble(id_ex_bubble),
      .stall_active(stall_active)
`ifdef HAZ_SEQ_PERF_CNT_EN
      ,
      .stall_cycles(stall_cycles),
      .flush_count(flush_count)
`endif
   );

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      checks++;
      if (got === exp) passed++;
      else $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
   endtask

   // stall cycles demanded by the instruction in ID, straight from the hazard rules
   function automatic int stallsNeeded(input logic [5:0] op, input logic [4:0] rs, input logic [4:0] rt,
                                       input logic exMr, input logic exRw, input logic [4:0] exD,
                                       input logic memMr, input logic [4:0] memD);
      bit readsRs = op != 6'd2;
      bit readsRt = op == 6'd0 || op == 6'd4 || op == 6'd5 || op == 6'd43;
      bit branch = op == 6'd4 || op == 6'd5;
      bit exHit = exD != 0 && ((readsRs && exD == rs) || (readsRt && exD == rt));
      bit memHit = memD != 0 && ((readsRs && memD == rs) || (readsRt && memD == rt));
      if (exMr && exHit) return branch ? LW_BEQ_STALLS : 1;
      if (exRw && exHit && branch) return 1;
      if (memMr && memHit && branch) return 1;
      return 0;
   endfunction

   task automatic cycle(input logic r, input logic [5:0] op, input logic [4:0] rs, input logic [4:0] rt,
                        input logic exMr, input logic exRw, input logic [4:0] exD,
                        input logic memMr, input logic [4:0] memD, input logic tk);
      bit expStall, expFlush, expActive;
      int n;
      @(negedge clk);
      reset = r; id_opcode = op; id_rs = rs; id_rt = rt;
      ex_memread = exMr; ex_regwrite = exRw; ex_dest = exD;
      mem_memread = memMr; mem_dest = memD; id_branch_taken = tk;
      #1;
      expFlush = 0;
      expActive = 0;
      if (r) begin
         pending = 0;
         expStall = 1;
      end else if (pending > 0) begin
         expStall = 1;
         expActive = 1;
         pending--;
      end else begin
         n = stallsNeeded(op, rs, rt, exMr, exRw, exD, memMr, memD);
         expStall = n > 0;
         expFlush = n == 0 && (((op == 6'd4 || op == 6'd5) && tk) || op == 6'd2);
         if (n > 1) pending = n - 1;
      end
      check("pc_write", 32'(pc_write), 32'(!expStall));
      check("if_id_write", 32'(if_id_write), 32'(!expStall));
      check("id_ex_bubble", 32'(id_ex_bubble), 32'(expStall));
      check("if_id_flush", 32'(if_id_flush), 32'(expFlush));
      check("stall_active", 32'(stall_active), 32'(expActive));
`ifdef HAZ_SEQ_PERF_CNT_EN
      if (r) begin
         modelStalls = 0;
         modelFlushes = 0;
      end
      check("stall_cycles", stall_cycles, 32'(modelStalls));
      check("flush_count", flush_count, 32'(modelFlushes));
      if (!r && expStall) modelStalls++;
      if (expFlush) modelFlushes++;
`endif
   endtask

   initial begin
      logic [5:0] ops [7] = '{6'd0, 6'd2, 6'd4, 6'd5, 6'd35, 6'd43, 6'd8};
      cycle(1, 0, 0, 0, 0, 0, 0, 0, 0, 0);
      cycle(1, 4, 1, 1, 1, 1, 1, 1, 1, 1);
      cycle(0, 0, 2, 7, 1, 1, 2, 0, 0, 0);
      cycle(0, 0, 2, 7, 0, 0, 0, 1, 2, 0);
      cycle(0, 4, 3, 4, 1, 1, 3, 0, 0, 1);
      cycle(0, 4, 3, 4, 0, 0, 0, 1, 3, 1);
      cycle(0, 4, 3, 4, 0, 0, 0, 0, 0, 1);
      cycle(0, 5, 1, 5, 0, 1, 5, 0, 0, 0);
      cycle(0, 5, 1, 5, 0, 0, 0, 0, 0, 0);
      cycle(0, 5, 0, 0, 0, 1, 0, 0, 0, 0);
      cycle(0, 4, 1, 2, 0, 0, 0, 0, 0, 1);
      cycle(0, 2, 9, 9, 1, 1, 9, 1, 9, 0);
      cycle(0, 4, 3, 4, 1, 1, 3, 0, 0, 1);
      cycle(1, 4, 3, 4, 0, 0, 0, 1, 3, 1);
      cycle(0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
      cycle(0, 43, 6, 7, 1, 1, 7, 0, 0, 0);
      cycle(0, 4, 6, 8, 0, 0, 0, 1, 8, 1);
      for (int i = 0; i < 500; i++)
         cycle($urandom_range(0, 99) < 3, ops[$urandom_range(0, 6)],
               5'($urandom_range(0, 3)), 5'($urandom_range(0, 3)),
               1'($urandom), 1'($urandom), 5'($urandom_range(0, 3)),
               1'($urandom), 5'($urandom_range(0, 3)), 1'($urandom));
      $display("%0d/%0d checks passed", passed, checks);
      $finish;
   end
endmodule
